// File: rtl/pin_entry_controller.sv
// Keypad front end for the start-check path: accumulates decimal digits, presents
// the PIN to the lock for one cycle, then unlocks, counts a failure or locks out.
module pin_entry_controller #(
  parameter int MAX_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_digit_valid,
  input  logic [3:0]  i_digit,
  input  logic        i_clear,
  input  logic        i_enter,
  input  logic        i_lock_req,
  input  logic        i_key_ok,
  output logic [15:0] o_pin,
  output logic        o_unlocked,
  output logic        o_locked_out,
  output logic [2:0]  o_digit_count,
  output logic [2:0]  o_fail_count,
  output logic        o_entry_error
);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_PRESENT,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [15:0] r_pin;
  logic [15:0] r_lcnt;
  logic [2:0]  r_dcnt;
  logic [2:0]  r_fail;
  logic        r_unlocked;
  logic        r_locked_out;
  logic        r_err;

  logic        w_digit_ok;
  logic [15:0] w_acc_next;
  logic [2:0]  w_fail_inc;

  assign w_digit_ok = (i_digit <= 4'd9) && (r_dcnt < 3'(MAX_DIGITS));
  assign w_acc_next = 16'(r_acc * 16'd10) + {12'd0, i_digit};
  assign w_fail_inc = r_fail + 3'd1;

  // r_pin is only non-zero in PRESENT and UNLOCKED, so the lock never sees a partial entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ENTRY;
      r_acc        <= '0;
      r_pin        <= '0;
      r_lcnt       <= '0;
      r_dcnt       <= '0;
      r_fail       <= '0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (i_clear) begin
            r_acc  <= '0;
            r_dcnt <= '0;
          end else if (i_enter) begin
            if (r_dcnt != 3'd0) begin
              r_state <= S_PRESENT;
              r_pin   <= r_acc;
            end
          end else if (i_digit_valid) begin
            if (w_digit_ok) begin
              r_acc  <= w_acc_next;
              r_dcnt <= r_dcnt + 3'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_PRESENT: begin
          if (i_key_ok) begin
            r_state    <= S_UNLOCKED;
            r_unlocked <= 1'b1;
            r_fail     <= '0;
          end else begin
            r_fail <= w_fail_inc;
            r_acc  <= '0;
            r_dcnt <= '0;
            r_pin  <= '0;
            if (w_fail_inc == 3'(MAX_TRIES)) begin
              r_state      <= S_LOCKOUT;
              r_locked_out <= 1'b1;
              r_lcnt       <= 16'(LOCKOUT_CYCLES);
            end else begin
              r_state <= S_ENTRY;
            end
          end
        end
        S_UNLOCKED: begin
          if (i_lock_req) begin
            r_state    <= S_ENTRY;
            r_acc      <= '0;
            r_dcnt     <= '0;
            r_pin      <= '0;
            r_unlocked <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          // Leaving the cycle the counter reads 1 gives exactly LOCKOUT_CYCLES cycles here.
          if (r_lcnt <= 16'd1) begin
            r_state      <= S_ENTRY;
            r_locked_out <= 1'b0;
            r_fail       <= '0;
          end else begin
            r_lcnt <= r_lcnt - 16'd1;
          end
        end
        default: r_state <= S_ENTRY;
      endcase
    end
  end

  assign o_pin         = r_pin;
  assign o_unlocked    = r_unlocked;
  assign o_locked_out  = r_locked_out;
  assign o_digit_count = r_dcnt;
  assign o_fail_count  = r_fail;
  assign o_entry_error = r_err;

endmodule

// File: tb/tb_pin_entry_controller.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor detects
// DUT events (error pulse, PRESENT, unlock/relock, lockout edges, fail count) and compares.
module tb_pin_entry_controller;

  localparam int LOCK = 1000;
  localparam int EV_ERR = 0, EV_PRESENT = 1, EV_UNLOCK = 2, EV_RELOCK = 3,
                 EV_LOCKIN = 4, EV_LOCKDONE = 5, EV_FAIL = 6;

  typedef struct { int kind; int val; } ev_t;

  logic        clk, rst_n;
  logic        digit_valid, clear, enter, lock_req, key_ok;
  logic [3:0]  digit;
  logic [15:0] pin;
  logic        unlocked, locked_out, entry_error;
  logic [2:0]  digit_count, fail_count;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  pin_entry_controller #(.MAX_DIGITS(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_digit_valid(digit_valid), .i_digit(digit), .i_clear(clear), .i_enter(enter),
    .i_lock_req(lock_req), .i_key_ok(key_ok),
    .o_pin(pin), .o_unlocked(unlocked), .o_locked_out(locked_out),
    .o_digit_count(digit_count), .o_fail_count(fail_count), .o_entry_error(entry_error)
  );

  // Lock model: the only accepted code is 9999.
  assign key_ok = (pin == 16'd9999);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic got(input int kind, input int val);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d val %0d, expected none", kind, val);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_bad++;
        $display("FAIL event: got kind %0d val %0d, expected kind %0d val %0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor
  initial begin
    logic p_unl, p_lo;
    logic [2:0] p_fail;
    int lcnt;
    p_unl = 0; p_lo = 0; p_fail = 0; lcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_unl = unlocked; p_lo = locked_out; p_fail = fail_count; lcnt = 0;
      end else begin
        if (entry_error) got(EV_ERR, int'(digit_count));
        if (pin != 16'd0 && !unlocked && !locked_out) got(EV_PRESENT, int'(pin));
        if (unlocked && !p_unl) got(EV_UNLOCK, int'(pin));
        if (!unlocked && p_unl) got(EV_RELOCK, int'(pin) * 8 + int'(digit_count));
        if (locked_out) lcnt++;
        if (locked_out && !p_lo) got(EV_LOCKIN, int'(pin));
        if (!locked_out && p_lo) begin
          got(EV_LOCKDONE, lcnt);
          lcnt = 0;
        end
        if (fail_count != p_fail) got(EV_FAIL, int'(fail_count));
        p_unl = unlocked; p_lo = locked_out; p_fail = fail_count;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    digit_valid = 1'b1;
    digit = 4'(d);
    cyc();
    digit_valid = 1'b0;
  endtask

  task automatic do_enter();
    enter = 1'b1;
    cyc();
    enter = 1'b0;
  endtask

  // One wrong 1234 attempt; t is the resulting consecutive-failure count.
  task automatic bad_try(input int t);
    press(1); press(2); press(3); press(4);
    expect_ev(EV_PRESENT, 1234);
    if (t < 3) expect_ev(EV_FAIL, t);
    else begin
      expect_ev(EV_LOCKIN, 0);
      expect_ev(EV_FAIL, 3);
    end
    do_enter();
    chk("present_pin", int'(pin), 1234);
    cyc();
    chk("fail_count_after_try", int'(fail_count), t);
  endtask

  task automatic good_pin();
    press(9); press(9); press(9); press(9);
    expect_ev(EV_PRESENT, 9999);
    expect_ev(EV_UNLOCK, 9999);
    do_enter();
    chk("present_pin_9999", int'(pin), 9999);
    chk("unlocked_in_present", int'(unlocked), 0);
    cyc();
    chk("unlocked_after_enter", int'(unlocked), 1);
    chk("fail_after_unlock", int'(fail_count), 0);
  endtask

  task automatic relock();
    expect_ev(EV_RELOCK, 0);
    lock_req = 1'b1;
    cyc();
    lock_req = 1'b0;
    chk("relock_unlocked", int'(unlocked), 0);
    chk("relock_pin", int'(pin), 0);
    chk("relock_dcnt", int'(digit_count), 0);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; digit_valid = 0; digit = 0; clear = 0; enter = 0; lock_req = 0;
    #1;
    chk("rst_pin", int'(pin), 0);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_locked_out", int'(locked_out), 0);
    chk("rst_dcnt", int'(digit_count), 0);
    chk("rst_fail", int'(fail_count), 0);
    chk("rst_err", int'(entry_error), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Illegal digit rejected
    expect_ev(EV_ERR, 0);
    press(12);
    chk("dcnt_after_bad_digit", int'(digit_count), 0);

    // Empty enter ignored; clear discards entry
    do_enter();
    cyc();
    chk("empty_enter_fail", int'(fail_count), 0);
    chk("empty_enter_dcnt", int'(digit_count), 0);
    press(5); press(5);
    chk("dcnt_55", int'(digit_count), 2);
    clear = 1'b1; digit_valid = 1'b1; digit = 4'd7;
    cyc();
    clear = 1'b0; digit_valid = 1'b0;
    chk("dcnt_after_clear", int'(digit_count), 0);
    // enter with digit_valid: digit dropped silently, enter ignored (no digits)
    enter = 1'b1; digit_valid = 1'b1; digit = 4'd3;
    cyc();
    enter = 1'b0; digit_valid = 1'b0;
    chk("enter_digit_dcnt", int'(digit_count), 0);

    // Fifth digit rejected, still unlocks with 9999
    press(9); press(9); press(9); press(9);
    expect_ev(EV_ERR, 4);
    press(9);
    chk("dcnt_after_fifth", int'(digit_count), 4);
    expect_ev(EV_PRESENT, 9999);
    expect_ev(EV_UNLOCK, 9999);
    do_enter();
    chk("present_pin_9999", int'(pin), 9999);
    cyc();
    chk("unlocked_after_enter", int'(unlocked), 1);

    // Inputs ignored while unlocked
    press(3);
    clear = 1'b1; cyc(); clear = 1'b0;
    do_enter();
    chk("unl_pin_held", int'(pin), 9999);
    chk("unl_dcnt", int'(digit_count), 4);
    chk("unl_still", int'(unlocked), 1);
    relock();

    // Clear-then-correct unlock
    press(5); press(5);
    clear = 1'b1; cyc(); clear = 1'b0;
    good_pin();
    relock();

    // Lockout after three failures
    bad_try(1);
    bad_try(2);
    bad_try(3);
    chk("locked_out_high", int'(locked_out), 1);
    lock_req = 1'b1; press(1); lock_req = 1'b0;
    chk("lockout_pin", int'(pin), 0);
    expect_ev(EV_LOCKDONE, LOCK);
    expect_ev(EV_FAIL, 0);
    waited = 0;
    while (locked_out && waited < LOCK + 100) begin
      cyc();
      waited++;
    end
    if (locked_out) begin
      n_cmp++; n_bad++;
      $display("FAIL lockout_timeout: still locked after %0d cycles, expected release", waited);
    end
    chk("fail_after_lockout", int'(fail_count), 0);
    press(9);
    chk("first_press_after_lockout", int'(digit_count), 1);
    clear = 1'b1; cyc(); clear = 1'b0;

    // Reset mid-lockout
    bad_try(1);
    bad_try(2);
    bad_try(3);
    repeat (50) cyc();
    chk("mid_lockout", int'(locked_out), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_locked_out", int'(locked_out), 0);
    chk("rstmid_fail", int'(fail_count), 0);
    chk("rstmid_pin", int'(pin), 0);
    chk("rstmid_dcnt", int'(digit_count), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    good_pin();

    repeat (3) cyc();
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
